// File: rtl/magnetron_pkg.sv
// Shared cook-state encoding and duty-window helper for the magnetron power controller.
package magnetron_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COOK  = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } cook_state_e;

   // Clocks of magnetron-on time contributed by each power level within one window.
   function automatic int unsigned slots_per_level(input int unsigned cycle_len,
                                                   input int unsigned num_levels);
      return cycle_len / num_levels;
   endfunction

endpackage

// File: rtl/magnetron_power_ctrl_duty.sv
// Duty-window generator: phase counter, wrap strobe and on/off compare against the effective level.
module duty_cycle_gen
   import magnetron_pkg::*;
#(
   parameter int unsigned NUM_LEVELS = 10,
   parameter int unsigned CYCLE_LEN  = 100,
   parameter int unsigned PWR_W      = $clog2(NUM_LEVELS + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic             restart_i,
   input  logic [PWR_W-1:0] eff_level_i,
   output logic             on_o,
   output logic             wrap_o
);

   localparam int unsigned PH_W  = $clog2(CYCLE_LEN);
   localparam int unsigned TH_W  = $clog2(CYCLE_LEN + 1);
   localparam int unsigned SLOTS = slots_per_level(CYCLE_LEN, NUM_LEVELS);
   localparam int unsigned LAST  = CYCLE_LEN - 1;

   logic [PH_W-1:0] phase_q, phase_d;
   logic [TH_W-1:0] thresh;

   assign wrap_o = en_i && (phase_q == PH_W'(LAST));

   always_comb begin
      phase_d = phase_q;
      if (restart_i) begin
         phase_d = '0;
      end else if (en_i) begin
         phase_d = wrap_o ? '0 : phase_q + PH_W'(1);
      end
   end

   // Compare against the next phase so the registered output lines up with the counter.
   assign thresh = TH_W'(eff_level_i) * TH_W'(SLOTS);
   assign on_o   = TH_W'(phase_d) < thresh;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         phase_q <= '0;
      end else begin
         phase_q <= phase_d;
      end
   end

endmodule

// File: rtl/magnetron_power_ctrl.sv
// Cook FSM and duty-cycled magnetron drive with door interlock.
// Optional soft-start ramp enabled by defining MAGNETRON_SOFT_START_EN.
module magnetron_power_ctrl
   import magnetron_pkg::*;
#(
   parameter int unsigned NUM_LEVELS = 10,
   parameter int unsigned CYCLE_LEN  = 100,
   parameter int unsigned PWR_W      = $clog2(NUM_LEVELS + 1)
) (
   input  logic             clk,
   input  logic             reset_,
   input  logic             start_,
   input  logic             stop_,
   input  logic             clear_,
   input  logic             door_closed,
   input  logic             timer_done,
   input  logic [PWR_W-1:0] power_level,
   output logic             mag_on,
   output logic [1:0]       cook_state,
   output logic             done_pulse
);

   cook_state_e      state_q, state_d;
   logic [PWR_W-1:0] level_q, level_d, level_clamp, eff_level;
   logic             mag_q, done_q;
   logic             duty_on, wrap, cook_en, cook_restart;

   assign level_clamp = (power_level > PWR_W'(NUM_LEVELS)) ? PWR_W'(NUM_LEVELS) : power_level;

   // Priority: clear > timer > stop/door > start.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (clear_ && stop_ && door_closed && !start_ && (power_level != '0))
               state_d = ST_COOK;
         end
         ST_COOK: begin
            if (!clear_)                    state_d = ST_IDLE;
            else if (timer_done)            state_d = ST_DONE;
            else if (!stop_ || !door_closed) state_d = ST_PAUSE;
         end
         ST_PAUSE: begin
            if (!clear_)                                  state_d = ST_IDLE;
            else if (timer_done)                          state_d = ST_DONE;
            else if (stop_ && door_closed && !start_)     state_d = ST_COOK;
         end
         ST_DONE: begin
            if (!clear_ || !door_closed) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      level_d = level_q;
      if (state_d == ST_IDLE) begin
         level_d = '0;
      end else if ((state_q == ST_IDLE) && (state_d == ST_COOK)) begin
         level_d = level_clamp;
      end
   end

   assign cook_restart = (state_d == ST_COOK) && (state_q != ST_COOK);
   assign cook_en      = (state_d == ST_COOK) && (state_q == ST_COOK);

`ifdef MAGNETRON_SOFT_START_EN
   logic [PWR_W-1:0] ramp_q, ramp_d;

   always_comb begin
      ramp_d = ramp_q;
      if (cook_restart) begin
         ramp_d = PWR_W'(1);
      end else if (wrap && (ramp_q < level_q)) begin
         ramp_d = ramp_q + PWR_W'(1);
      end
   end

   assign eff_level = (ramp_d < level_d) ? ramp_d : level_d;

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         ramp_q <= '0;
      end else begin
         ramp_q <= ramp_d;
      end
   end
`else
   logic unused_wrap;

   assign eff_level   = level_d;
   assign unused_wrap = wrap;
`endif

   duty_cycle_gen #(
      .NUM_LEVELS (NUM_LEVELS),
      .CYCLE_LEN  (CYCLE_LEN),
      .PWR_W      (PWR_W)
   ) u_duty (
      .clk_i       (clk),
      .rst_ni      (reset_),
      .en_i        (cook_en),
      .restart_i   (cook_restart),
      .eff_level_i (eff_level),
      .on_o        (duty_on),
      .wrap_o      (wrap)
   );

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state_q <= ST_IDLE;
         level_q <= '0;
         mag_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         mag_q   <= (state_d == ST_COOK) && duty_on;
         done_q  <= (state_d == ST_DONE) && (state_q != ST_DONE);
      end
   end

   // Door interlock bypasses the register so an opening door cuts power immediately.
   assign mag_on     = mag_q & door_closed;
   assign cook_state = state_q;
   assign done_pulse = done_q;

endmodule

// File: tb/tb_magnetron_power_ctrl.sv
// Directed bench for magnetron_power_ctrl: transition table plus multi-cycle duty, interlock and reset sequences.
module tb_magnetron_power_ctrl;

   localparam int unsigned NL = 10;
   localparam int unsigned CL = 100;
   localparam int unsigned PW = $clog2(NL + 1);

   logic          clk = 1'b0;
   logic          reset_, start_, stop_, clear_, door_closed, timer_done;
   logic [PW-1:0] power_level;
   logic          mag_on, done_pulse;
   logic [1:0]    cook_state;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       st, sp, cl, dc, td;
      logic [3:0] pl;
      logic [1:0] es;
      logic       em, ed;
   } vec_t;

   vec_t vecs[16];

   magnetron_power_ctrl #(
      .NUM_LEVELS (NL),
      .CYCLE_LEN  (CL)
   ) dut (
      .clk         (clk),
      .reset_      (reset_),
      .start_      (start_),
      .stop_       (stop_),
      .clear_      (clear_),
      .door_closed (door_closed),
      .timer_done  (timer_done),
      .power_level (power_level),
      .mag_on      (mag_on),
      .cook_state  (cook_state),
      .done_pulse  (done_pulse)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic exp_mag(input int unsigned k, input int unsigned lvl);
      int unsigned eff;
      eff = lvl;
`ifdef MAGNETRON_SOFT_START_EN
      if ((k / CL) + 1 < lvl) eff = (k / CL) + 1;
`endif
      return (k % CL) < eff * (CL / NL);
   endfunction

   task automatic defaults();
      start_ = 1'b1; stop_ = 1'b1; clear_ = 1'b1;
      door_closed = 1'b1; timer_done = 1'b0;
   endtask

   // Caller drives start_ low beforehand; k counts edges since entry into COOK.
   task automatic run_cook(input int unsigned lvl, input int unsigned n, input string tag);
      for (int unsigned k = 0; k < n; k++) begin
         step();
         start_ = 1'b1;
         if (k == 0) check({tag, "_state"}, 32'(cook_state), 32'd1);
         check($sformatf("%s_k%0d", tag, k), 32'(mag_on), 32'(exp_mag(k, lvl)));
      end
   endtask

   task automatic go_idle(input string tag);
      clear_ = 1'b0;
      step();
      clear_ = 1'b1;
      check({tag, "_idle"}, 32'(cook_state), 32'd0);
      check({tag, "_idle_mag"}, 32'(mag_on), 32'd0);
   endtask

   initial begin
      //           st    sp    cl    dc    td    pl     es     em    ed
      vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  2'd0, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd5,  2'd0, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd5,  2'd0, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd3,  2'd1, 1'b1, 1'b0};
      vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd3,  2'd1, 1'b1, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3,  2'd2, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd3,  2'd2, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd7,  2'd1, 1'b1, 1'b0};
      vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd7,  2'd3, 1'b0, 1'b1};
      vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd7,  2'd3, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  2'd0, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd15, 2'd1, 1'b1, 1'b0};
      vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd15, 2'd0, 1'b0, 1'b0};
      vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1,  2'd1, 1'b1, 1'b0};
      vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1,  2'd2, 1'b0, 1'b0};
      vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1,  2'd0, 1'b0, 1'b0};

      reset_ = 1'b0;
      defaults();
      power_level = '0;
      #12;
      check("rst_state", 32'(cook_state), 32'd0);
      check("rst_mag", 32'(mag_on), 32'd0);
      check("rst_done", 32'(done_pulse), 32'd0);
      reset_ = 1'b1;

      for (int i = 0; i < 16; i++) begin
         start_ = vecs[i].st; stop_ = vecs[i].sp; clear_ = vecs[i].cl;
         door_closed = vecs[i].dc; timer_done = vecs[i].td;
         power_level = PW'(vecs[i].pl);
         step();
         check($sformatf("row%0d_state", i), 32'(cook_state), 32'(vecs[i].es));
         check($sformatf("row%0d_mag", i), 32'(mag_on), 32'(vecs[i].em));
         check($sformatf("row%0d_done", i), 32'(done_pulse), 32'(vecs[i].ed));
      end
      defaults();

      // Level 5 duty over two full windows.
      start_ = 1'b0; power_level = PW'(5);
      run_cook(5, 2 * CL, "duty5");
      go_idle("duty5");

      // Interlock mid-window, then resume with phase restarted and level retained.
      start_ = 1'b0; power_level = PW'(5);
      run_cook(5, 30, "pre_door");
      door_closed = 1'b0;
      #1;
      check("interlock_mag", 32'(mag_on), 32'd0);
      check("interlock_state", 32'(cook_state), 32'd1);
      step();
      check("door_pause_state", 32'(cook_state), 32'd2);
      check("door_pause_mag", 32'(mag_on), 32'd0);
      door_closed = 1'b1;
      step();
      check("pause_hold_state", 32'(cook_state), 32'd2);
      check("pause_hold_mag", 32'(mag_on), 32'd0);
      start_ = 1'b0; power_level = '0;
      run_cook(5, CL, "resume");
      go_idle("resume");

      // Out-of-range request clamps to full power.
      start_ = 1'b0; power_level = PW'(15);
      run_cook(NL, CL + 50, "clamp15");
      go_idle("clamp15");

      // Asynchronous reset mid-cook.
      start_ = 1'b0; power_level = PW'(10);
      run_cook(NL, 5, "pre_rst");
      reset_ = 1'b0;
      #1;
      check("async_rst_mag", 32'(mag_on), 32'd0);
      check("async_rst_state", 32'(cook_state), 32'd0);
      #2;
      reset_ = 1'b1;
      step();
      check("post_rst_state", 32'(cook_state), 32'd0);
      check("post_rst_mag", 32'(mag_on), 32'd0);
      start_ = 1'b0;
      run_cook(NL, 3, "after_rst");
      go_idle("after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/magnetron_power_ctrl.md
Name: magnetron_power_ctrl

Overview:
Clocked, parametrised successor to the combinational magnetron set/reset logic in the microwave oven controller. It owns the cook state machine (idle/cook/pause/done) and drives the magnetron directly. Output power is selected by duty-cycling the magnetron over a fixed window. It sits between the keypad/timer blocks and the magnetron driver.

Parameters:
NUM_LEVELS, 10, number of nonzero power levels; level L gives an on-fraction of L/NUM_LEVELS.
CYCLE_LEN, 100, clocks per duty window; must be an integer multiple of NUM_LEVELS.
PWR_W, $clog2(NUM_LEVELS+1), width of power_level (derived; do not override).

Ports:
clk  input  1  system clock
reset_  input  1  asynchronous, active-low reset
start_  input  1  start key, active-low, already synchronised to clk
stop_  input  1  stop key, active-low, already synchronised
clear_  input  1  clear key, active-low, already synchronised
door_closed  input  1  1 = door closed
timer_done  input  1  cook timer expired (level)
power_level  input  PWR_W  requested level; sampled only on IDLE->COOK
mag_on  output  1  magnetron enable
cook_state  output  2  0 IDLE, 1 COOK, 2 PAUSE, 3 DONE
done_pulse  output  1  single-cycle pulse on entry to DONE

Behaviour:
- Reset (async assert, sync release): state IDLE, level_q=0, phase=0, mag_q=0, done_pulse=0.
- All inputs sampled on the rising edge of clk.
- Event priority per cycle: clear_ low > timer_done > (stop_ low or door open) > start_ low.
- IDLE:
  - start_ low, door_closed=1 and power_level!=0 -> COOK; level_q <= min(power_level, NUM_LEVELS).
  - start_ low with power_level=0 or door open -> stay IDLE.
- COOK:
  - clear_ low -> IDLE, level_q <= 0.
  - timer_done -> DONE.
  - stop_ low or door_closed=0 -> PAUSE.
- PAUSE:
  - clear_ low -> IDLE.
  - timer_done -> DONE.
  - start_ low with door_closed=1 -> COOK; level_q retained.
- DONE:
  - clear_ low or door_closed=0 -> IDLE.
  - start_ ignored.
- Phase counter: 0..CYCLE_LEN-1 and wraps; counts only in COOK; forced to 0 on every entry into COOK.
- Duty: mag_q <= (next_state==COOK) && (phase_next < eff_level*(CYCLE_LEN/NUM_LEVELS)).
  - mag_on rises the cycle after start_ is sampled low.
  - Level NUM_LEVELS gives a continuous on.
- Interlock: mag_on = mag_q & door_closed. Combinational, so door opening kills the magnetron with zero latency, independent of the registered state.
- done_pulse is registered; high exactly one cycle, the cycle after the transition into DONE.
- timer_done held high while in DONE has no further effect.
- Reset mid-cook: mag_on drops asynchronously.

Optional Feature:
MAGNETRON_SOFT_START_EN.
- Defined: every entry into COOK sets ramp=1. ramp increments at each phase wrap until it reaches level_q. eff_level = min(level_q, ramp).
- Undefined: eff_level = level_q; no ramp logic is synthesised.

Decomposition:
- Package magnetron_pkg: state encodings (IDLE/COOK/PAUSE/DONE as 2-bit localparams) and a slots-per-level helper function.
- Sub-module duty_cycle_gen: phase counter, wrap strobe and compare, with inputs en, restart and eff_level, and output on. The FSM stays in magnetron_power_ctrl.

Test Plan:
1. NUM_LEVELS=10, CYCLE_LEN=100, level 5, door closed, start_ pulse -> cook_state=1 next cycle; mag_on high for phases 0-49 and low for 50-99, repeating.
2. Cooking at level 10, then door_closed -> 0 mid-window -> mag_on low in the same cycle; cook_state=2 next edge. Close door and press start_ -> resume at level 10 with phase restarted at 0.
3. Same cycle: timer_done=1, stop_=0, clear_=1 -> DONE (not PAUSE); done_pulse high for exactly one cycle. Then clear_ -> IDLE.
4. IDLE with power_level=0 or 15 -> start with 0 is ignored; start with 15 is clamped to 10 (continuous on).
5. reset_ asserted asynchronously mid-COOK -> mag_on=0 and cook_state=0 immediately. After release, start_ is required to cook again.
6. With MAGNETRON_SOFT_START_EN, level 4 -> windows 1-4 give on-counts 10, 20, 30, 40, then 40 steady.
